// File: rtl/draw_pkg.sv
// Shared widths, state encodings and defaults for the drawing-engine arbiter.
package draw_pkg;

   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int C_W    = 3;
   localparam int HOLD_W = 16;

   localparam logic [HOLD_W-1:0] DEFAULT_TIMEOUT = 16'd20000;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      OWN     = 2'b01,
      RELEASE = 2'b10
   } state_t;

   // Index width for an n-entry requester set, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// Bundle of requester-side and VGA-side signals shared between the drawing engines and the arbiter.
interface draw_arbiter_if
   import draw_pkg::*;
#(
   parameter int NUM_REQ = 4
);

   logic [NUM_REQ-1:0]     req;
   logic [NUM_REQ-1:0]     eng_done;
   logic [NUM_REQ*X_W-1:0] eng_x;
   logic [NUM_REQ*Y_W-1:0] eng_y;
   logic [NUM_REQ*C_W-1:0] eng_colour;
   logic [NUM_REQ-1:0]     eng_plot;

   logic [NUM_REQ-1:0]     grant;
   logic [X_W-1:0]         x;
   logic [Y_W-1:0]         y;
   logic [C_W-1:0]         colour;
   logic                   plot;
   logic                   busy;
   logic                   timeout_err;

   modport master (
      output req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
      input  grant, x, y, colour, plot, busy, timeout_err
   );

   modport slave (
      input  req, eng_done, eng_x, eng_y, eng_colour, eng_plot,
      output grant, x, y, colour, plot, busy, timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: lowest set request at or after ptr, wrapping, returned one-hot.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [2*NUM_REQ-1:0] win_dbl;
   logic [NUM_REQ-1:0]   rot_req;
   logic [NUM_REQ-1:0]   rot_win;

   // Rotate so ptr sits at bit 0, isolate the lowest set bit, then rotate back.
   always_comb begin
      req_dbl = {req, req};
      rot_req = NUM_REQ'(req_dbl >> ptr);
      rot_win = rot_req & (~rot_req + NUM_REQ'(1));
      win_dbl = {{NUM_REQ{1'b0}}, rot_win} << ptr;
      winner  = win_dbl[NUM_REQ-1:0] | win_dbl[2*NUM_REQ-1:NUM_REQ];
      valid   = |req;
   end

endmodule

// File: rtl/draw_arbiter.sv
// Grants the single VGA pixel port to one drawing engine at a time, round-robin, with a hold timeout.
module draw_arbiter
   import draw_pkg::*;
#(
   parameter int                NUM_REQ = 4,
   parameter logic [HOLD_W-1:0] TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic           clk,
   input  logic           reset,
   draw_arbiter_if.slave  bus
);

   localparam int               IDX_W    = idx_width(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   state_t              state;
   state_t              next_state;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    win_idx;
   logic [NUM_REQ-1:0]  winner;
   logic                win_valid;
   logic [NUM_REQ-1:0]  grant_q;
   logic [HOLD_W-1:0]   hold_cnt;
   logic                timeout_err_q;

   logic                own_req;
   logic                own_done;
   logic                own_plot;
   logic [X_W-1:0]      own_x;
   logic [Y_W-1:0]      own_y;
   logic [C_W-1:0]      own_colour;

   logic                timeout_hit;
   logic                leave_own;
   logic                set_err;
   logic                in_own;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (bus.req),
      .ptr    (ptr),
      .winner (winner),
      .valid  (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   // Everything the FSM and output mux need from the current owner, so other engines are invisible.
   always_comb begin
      own_req    = 1'b0;
      own_done   = 1'b0;
      own_plot   = 1'b0;
      own_x      = '0;
      own_y      = '0;
      own_colour = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == IDX_W'(i)) begin
            own_req    = bus.req[i];
            own_done   = bus.eng_done[i];
            own_plot   = bus.eng_plot[i];
            own_x      = bus.eng_x[i*X_W +: X_W];
            own_y      = bus.eng_y[i*Y_W +: Y_W];
            own_colour = bus.eng_colour[i*C_W +: C_W];
         end
      end
   end

   assign timeout_hit = (hold_cnt == TIMEOUT - 16'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A done pulse in the timeout cycle is a normal finish, so it suppresses the error.
   always_comb begin
      next_state = state;
      leave_own  = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               next_state = OWN;
            end
         end
         OWN: begin
            if (own_done || !own_req || timeout_hit) begin
               next_state = RELEASE;
               leave_own  = 1'b1;
               set_err    = timeout_hit && !own_done;
            end
         end
         RELEASE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner         <= '0;
         ptr           <= '0;
         grant_q       <= '0;
         hold_cnt      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state == IDLE && win_valid) begin
            owner    <= win_idx;
            grant_q  <= winner;
            hold_cnt <= '0;
         end else if (leave_own) begin
            grant_q  <= '0;
            hold_cnt <= '0;
            ptr      <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
         end else if (state == OWN && hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 16'd1;
         end
         if (set_err) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign in_own          = (state == OWN);
   assign bus.grant       = grant_q;
   assign bus.busy        = (state != IDLE);
   assign bus.timeout_err = timeout_err_q;
   assign bus.x           = in_own ? own_x      : '0;
   assign bus.y           = in_own ? own_y      : '0;
   assign bus.colour      = in_own ? own_colour : '0;
   assign bus.plot        = in_own && own_plot;

endmodule
